// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan code decoder: folds E0/F0/E1 prefix sequences from the
// PS2_Controller byte stream into single registered key events.
module ps2_scancode_decoder #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 17
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_released,
  output logic       key_repeat,
  output logic [7:0] key_ascii,
  output logic       pause_pulse,
  output logic       seq_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GOT_E0,
    S_GOT_F0,
    S_GOT_E0F0,
    S_PAUSE_SKIP
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_tcnt;
  logic [2:0]       r_skip;
  logic [7:0]       r_held_code;
  logic             r_held_ext;
  logic             r_held_valid;

  logic       w_timeout;
  logic       w_is_prefix;
  logic       w_is_ignored;
  logic       w_emit;
  logic       w_ext;
  logic       w_rel;
  logic       w_err;
  logic       w_pause;
  logic       w_match;
  logic [7:0] w_ascii;

  assign w_is_prefix  = (received_data == 8'hE0) || (received_data == 8'hF0) ||
                        (received_data == 8'hE1);
  assign w_is_ignored = (received_data == 8'hFA) || (received_data == 8'hAA) ||
                        (received_data == 8'hEE) || (received_data == 8'hFE) ||
                        (received_data == 8'h00) || (received_data == 8'hFF);
  // A strobe in the same cycle always beats the timeout.
  assign w_timeout    = (r_state != S_IDLE) && !received_data_en && (r_tcnt == TO_LAST);
  assign w_match      = r_held_valid && ({r_held_ext, r_held_code} == {w_ext, received_data});

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (received_data_en) begin
      case (r_state)
        S_IDLE: begin
          if (received_data == 8'hE0)      w_state_next = S_GOT_E0;
          else if (received_data == 8'hF0) w_state_next = S_GOT_F0;
          else if (received_data == 8'hE1) w_state_next = S_PAUSE_SKIP;
          else                             w_state_next = S_IDLE;
        end
        S_GOT_E0:     w_state_next = (received_data == 8'hF0) ? S_GOT_E0F0 : S_IDLE;
        S_GOT_F0:     w_state_next = S_IDLE;
        S_GOT_E0F0:   w_state_next = S_IDLE;
        S_PAUSE_SKIP: w_state_next = (r_skip == 3'd1) ? S_IDLE : S_PAUSE_SKIP;
        default:      w_state_next = S_IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_next = S_IDLE;
    end
  end

  // Per-cycle actions decoded from state and the incoming byte
  always_comb begin
    w_emit  = 1'b0;
    w_ext   = 1'b0;
    w_rel   = 1'b0;
    w_err   = 1'b0;
    w_pause = 1'b0;
    if (received_data_en) begin
      case (r_state)
        S_IDLE: w_emit = !w_is_prefix && !w_is_ignored;
        S_GOT_E0: begin
          w_ext = 1'b1;
          if ((received_data == 8'hE0) || (received_data == 8'hE1)) w_err = 1'b1;
          else if (received_data != 8'hF0)                           w_emit = 1'b1;
        end
        S_GOT_F0: begin
          w_rel  = 1'b1;
          w_err  = w_is_prefix;
          w_emit = !w_is_prefix;
        end
        S_GOT_E0F0: begin
          w_ext  = 1'b1;
          w_rel  = 1'b1;
          w_err  = w_is_prefix;
          w_emit = !w_is_prefix;
        end
        S_PAUSE_SKIP: w_pause = (r_skip == 3'd1);
        default: w_err = 1'b0;
      endcase
    end else begin
      w_err = w_timeout;
    end
  end

  always_comb begin
    w_ascii = 8'h00;
    case (received_data)
      8'h1C: w_ascii = 8'h41;  8'h32: w_ascii = 8'h42;  8'h21: w_ascii = 8'h43;
      8'h23: w_ascii = 8'h44;  8'h24: w_ascii = 8'h45;  8'h2B: w_ascii = 8'h46;
      8'h34: w_ascii = 8'h47;  8'h33: w_ascii = 8'h48;  8'h43: w_ascii = 8'h49;
      8'h3B: w_ascii = 8'h4A;  8'h42: w_ascii = 8'h4B;  8'h4B: w_ascii = 8'h4C;
      8'h3A: w_ascii = 8'h4D;  8'h31: w_ascii = 8'h4E;  8'h44: w_ascii = 8'h4F;
      8'h4D: w_ascii = 8'h50;  8'h15: w_ascii = 8'h51;  8'h2D: w_ascii = 8'h52;
      8'h1B: w_ascii = 8'h53;  8'h2C: w_ascii = 8'h54;  8'h3C: w_ascii = 8'h55;
      8'h2A: w_ascii = 8'h56;  8'h1D: w_ascii = 8'h57;  8'h22: w_ascii = 8'h58;
      8'h35: w_ascii = 8'h59;  8'h1A: w_ascii = 8'h5A;
      8'h45: w_ascii = 8'h30;  8'h16: w_ascii = 8'h31;  8'h1E: w_ascii = 8'h32;
      8'h26: w_ascii = 8'h33;  8'h25: w_ascii = 8'h34;  8'h2E: w_ascii = 8'h35;
      8'h36: w_ascii = 8'h36;  8'h3D: w_ascii = 8'h37;  8'h3E: w_ascii = 8'h38;
      8'h46: w_ascii = 8'h39;
      8'h29: w_ascii = 8'h20;  8'h5A: w_ascii = 8'h0D;  8'h66: w_ascii = 8'h08;
      default: w_ascii = 8'h00;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_tcnt       <= '0;
      r_skip       <= 3'd0;
      r_held_code  <= 8'h00;
      r_held_ext   <= 1'b0;
      r_held_valid <= 1'b0;
      key_valid    <= 1'b0;
      key_code     <= 8'h00;
      key_extended <= 1'b0;
      key_released <= 1'b0;
      key_repeat   <= 1'b0;
      key_ascii    <= 8'h00;
      pause_pulse  <= 1'b0;
      seq_error    <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) || received_data_en || w_timeout) r_tcnt <= '0;
      else                                                       r_tcnt <= r_tcnt + 1'b1;

      if (received_data_en && (r_state == S_IDLE) && (received_data == 8'hE1))
        r_skip <= 3'd7;
      else if (received_data_en && (r_state == S_PAUSE_SKIP))
        r_skip <= r_skip - 3'd1;

      key_valid   <= w_emit;
      pause_pulse <= w_pause;
      seq_error   <= w_err;

      if (w_emit) begin
        key_code     <= received_data;
        key_extended <= w_ext;
        key_released <= w_rel;
        key_repeat   <= !w_rel && w_match;
        key_ascii    <= w_ext ? 8'h00 : w_ascii;
        if (!w_rel) begin
          r_held_code  <= received_data;
          r_held_ext   <= w_ext;
          r_held_valid <= 1'b1;
        end else if (w_match) begin
          r_held_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed + random bench for ps2_scancode_decoder, checked against a
// sequence-level model that tracks the pending prefix bytes in a queue.
module tb_ps2_scancode_decoder;
  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_en = 1'b0;
  logic       key_valid, key_extended, key_released, key_repeat;
  logic       pause_pulse, seq_error;
  logic [7:0] key_code, key_ascii;

  int total = 0;
  int bad   = 0;
  int kv_cnt = 0;

  ps2_scancode_decoder #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .CLOCK_50        (clk),
    .resetn          (rst_n),
    .received_data   (rx_data),
    .received_data_en(rx_en),
    .key_valid       (key_valid),
    .key_code        (key_code),
    .key_extended    (key_extended),
    .key_released    (key_released),
    .key_repeat      (key_repeat),
    .key_ascii       (key_ascii),
    .pause_pulse     (pause_pulse),
    .seq_error       (seq_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (key_valid) kv_cnt++;

  // Reference model state
  logic [7:0] m_pend[$];
  logic       m_hv;
  logic [8:0] m_hk;
  logic [7:0] m_code, m_ascii;
  logic       m_ext, m_rel, m_rep;
  logic       e_valid, e_pause, e_err;

  logic [7:0] letters[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                              8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                              8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digits[10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  function automatic logic [7:0] ascii_ref(input logic [7:0] c);
    for (int i = 0; i < 26; i++) if (letters[i] == c) return 8'h41 + 8'(i);
    for (int i = 0; i < 10; i++) if (digits[i] == c) return 8'h30 + 8'(i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    if (c == 8'h66) return 8'h08;
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_pend.delete();
    m_hv = 0; m_hk = 9'h0;
    m_code = 0; m_ascii = 0; m_ext = 0; m_rel = 0; m_rep = 0;
    e_valid = 0; e_pause = 0; e_err = 0;
  endtask

  task automatic model_emit(input logic [7:0] b, input logic ext, input logic rel);
    e_valid = 1;
    m_code = b; m_ext = ext; m_rel = rel;
    m_rep = !rel && m_hv && (m_hk == {ext, b});
    m_ascii = ext ? 8'h00 : ascii_ref(b);
    if (!rel) begin
      m_hv = 1; m_hk = {ext, b};
    end else if (m_hv && m_hk == {ext, b}) begin
      m_hv = 0;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic has_e0, has_f0;
    e_valid = 0; e_pause = 0; e_err = 0;
    if (m_pend.size() == 0) begin
      if (b inside {8'hE0, 8'hF0, 8'hE1}) m_pend.push_back(b);
      else if (!(b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) model_emit(b, 0, 0);
    end else if (m_pend[0] == 8'hE1) begin
      m_pend.push_back(b);
      if (m_pend.size() == 8) begin
        e_pause = 1; m_pend.delete();
      end
    end else begin
      has_e0 = 0; has_f0 = 0;
      foreach (m_pend[i]) begin
        if (m_pend[i] == 8'hE0) has_e0 = 1;
        if (m_pend[i] == 8'hF0) has_f0 = 1;
      end
      if (has_e0 && !has_f0 && b == 8'hF0) begin
        m_pend.push_back(b);
      end else if (b inside {8'hE0, 8'hF0, 8'hE1}) begin
        e_err = 1; m_pend.delete();
      end else begin
        model_emit(b, has_e0, has_f0); m_pend.delete();
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fields(input string tag);
    chk({tag, ".code"}, key_code, m_code);
    chk({tag, ".ext"}, key_extended, m_ext);
    chk({tag, ".rel"}, key_released, m_rel);
    chk({tag, ".rep"}, key_repeat, m_rep);
    chk({tag, ".ascii"}, key_ascii, m_ascii);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_en = 1'b1;
    @(posedge clk); #1;
    rx_en = 1'b0;
    model_byte(b);
    $display("byte %02h: valid=%0b code=%02h ext=%0b rel=%0b rep=%0b ascii=%02h pause=%0b err=%0b",
             b, key_valid, key_code, key_extended, key_released, key_repeat, key_ascii,
             pause_pulse, seq_error);
    chk("valid", key_valid, e_valid);
    chk("pause", pause_pulse, e_pause);
    chk("err", seq_error, e_err);
    chk_fields("ev");
    @(posedge clk); #1;
    chk("valid_drop", key_valid, 1'b0);
    chk("pause_drop", pause_pulse, 1'b0);
    chk("err_drop", seq_error, 1'b0);
    chk_fields("hold");
  endtask

  initial begin
    int n, kv0, r;
    bit seen;
    logic [7:0] b;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.valid", key_valid, 1'b0);
    chk("rst.pause", pause_pulse, 1'b0);
    chk("rst.err", seq_error, 1'b0);
    chk_fields("rst");

    // Make, repeat, break, fresh make
    send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);

    // Extended make and break: exactly two pulses
    kv0 = kv_cnt;
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    @(posedge clk); #1;
    chk("ext.pulses", kv_cnt - kv0, 2);

    // Timeout after a dangling E0
    send(8'hE0);
    n = 0; seen = 0;
    for (int i = 0; i < TO + 10 && !seen; i++) begin
      @(posedge clk); #1;
      n++;
      if (seq_error) seen = 1;
      else chk("to.no_event", key_valid, 1'b0);
    end
    $display("timeout: seq_error after %0d cycles", n);
    chk("to.seen", seen, 1'b1);
    chk("to.latency", (n >= TO - 1 && n <= TO + 1), 1'b1);
    m_pend.delete();
    @(posedge clk); #1;
    chk("to.drop", seq_error, 1'b0);
    send(8'h45);

    // Pause sequence then an ignored ACK
    kv0 = kv_cnt;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    chk("pause.no_kv", kv_cnt - kv0, 0);
    send(8'hFA);

    // Reset in the middle of a break sequence
    send(8'hE0); send(8'hF0);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    model_reset();
    chk("midrst.valid", key_valid, 1'b0);
    chk("midrst.err", seq_error, 1'b0);
    chk_fields("midrst");
    @(negedge clk) rst_n = 1'b1;
    send(8'h5A);
    send(8'hF0); send(8'hE0);

    // Random byte stream
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 11);
      case (r)
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h75;
        3: b = 8'hFA;
        4: b = 8'($urandom);
        5, 6: b = digits[$urandom_range(0, 9)];
        default: b = letters[$urandom_range(0, 5)];
      endcase
      send(b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Consumes the byte stream from PS2_Controller (received_data plus its one-cycle new-data strobe) on CLOCK_50.
- Reassembles PS/2 Set-2 multi-byte sequences: E0 extended prefix, F0 break prefix, and the 8-byte E1 Pause sequence.
- Emits one registered key event per complete sequence, with code, extended, release, repeat and ASCII information.
- Feeds the benchmark game logic (reaction timer, typing test) and the HEX debug display.

Parameters:
TIMEOUT_CYCLES, 100000, idle cycles after a prefix byte before the partial sequence is discarded (2 ms at 50 MHz).
CNT_W, 17, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
CLOCK_50  input  1  system clock, 50 MHz; all logic on its rising edge.
resetn  input  1  synchronous, active-low reset (driven from KEY0 at top level).
received_data  input  8  byte from PS2_Controller.
received_data_en  input  1  one-cycle strobe; received_data is valid in that cycle.
key_valid  output  1  one-cycle pulse; the event fields below are valid in that cycle and hold until the next event.
key_code  output  8  final scan code byte (prefixes stripped).
key_extended  output  1  sequence carried an E0 prefix.
key_released  output  1  sequence carried an F0 prefix (break code).
key_repeat  output  1  make code equal to the currently held make code, i.e. typematic repeat.
key_ascii  output  8  ASCII for the mapped non-extended codes, else 8'h00.
pause_pulse  output  1  one-cycle pulse when a full E1 Pause sequence has been consumed.
seq_error  output  1  one-cycle pulse when a partial sequence is discarded (timeout or illegal byte).

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE. Timeout counter 0. Held-key register (held_code, held_ext, held_valid) is cleared. Reset takes effect at any point, including mid-sequence, with no event emitted.
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0, PAUSE_SKIP. Transitions happen only on cycles where received_data_en=1, except for timeout.
- IDLE:
  - E0 -> GOT_E0; F0 -> GOT_F0; E1 -> PAUSE_SKIP with skip counter = 7.
  - FA, AA, EE, FE, 00, FF -> ignored; stay IDLE, no event.
  - Any other byte -> emit a make event, stay IDLE.
- GOT_E0: F0 -> GOT_E0F0; any other byte -> emit an extended make, go to IDLE.
- GOT_F0: any byte -> emit a break, go to IDLE.
- GOT_E0F0: any byte -> emit an extended break, go to IDLE.
- Illegal bytes: E0, F0 or E1 arriving in GOT_F0 or GOT_E0F0, or E0/E1 in GOT_E0 -> pulse seq_error, go to IDLE, no event. E0 in GOT_E0F0 is covered by this rule.
- PAUSE_SKIP:
  - Each strobe decrements the skip counter; the byte contents are not checked.
  - When the 7th byte is consumed: pulse pause_pulse, go to IDLE, no key_valid.
- Event latency: key_valid and the event fields are registered and asserted on the cycle after the strobe of the final byte.
- Timeout:
  - The counter runs in every non-IDLE state and clears on each strobe.
  - When it reaches TIMEOUT_CYCLES-1 with no strobe: pulse seq_error and go to IDLE.
  - If a strobe arrives in the same cycle as the timeout, the strobe wins and is processed normally.
- Repeat and held-key tracking:
  - On a make event, key_repeat=1 if held_valid and {held_ext, held_code} equals the new {ext, code}. held_* is then loaded with the new key.
  - On a break event whose {ext, code} equals held_*, held_valid is cleared.
  - key_repeat is always 0 on break events.
- key_ascii:
  - Combinational table, registered with the event fields. Valid only for non-extended codes; extended events give 00. The value is the same for make and break events.
  - Letters A–Z -> 41–5A: 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z.
  - Digits 0–9 -> 30–39: 45, 16, 1E, 26, 25, 2E, 36, 3D, 3E, 46.
  - Other keys: 29 space -> 20, 5A enter -> 0D, 66 backspace -> 08. All other codes -> 00.
- key_valid, pause_pulse and seq_error are never asserted in the same cycle.

Test Plan:
- Reset, then strobe 1C -> one cycle later key_valid=1, key_code=1C, ext=0, rel=0, repeat=0, ascii=41; next cycle key_valid=0 while fields hold.
- Strobes 1C, 1C, F0, 1C -> second event repeat=1; third event rel=1, ascii=41, repeat=0; then strobe 1C -> repeat=0.
- Strobes E0, 75 -> key_code=75, ext=1, ascii=00; then E0, F0, 75 -> ext=1, rel=1; exactly two key_valid pulses total.
- Strobe E0, then no strobe for TIMEOUT_CYCLES (use TIMEOUT_CYCLES=20 in the bench) -> seq_error pulse; then strobe 45 -> non-extended event, ascii=30.
- Strobes E1 14 77 E1 F0 14 F0 77 -> one pause_pulse after the 8th byte, no key_valid; then strobe FA -> no output.
- Strobes E0, F0, then resetn=0 for one cycle, then strobe 5A -> make event, ext=0, rel=0, ascii=0D; strobe F0 then E0 -> seq_error, no event.
